// File: rtl/orsram_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the output-row SRAM array.
// Handshake: a requester raises *_req with its payload and holds both stable until
// the matching *_gnt is high in the same cycle; the transfer happens at that edge.
// rd_valid is a one-cycle pulse qualifying rd_data; there is no back-pressure on it.
interface orsram_arb_if #(
   parameter int SRAM_NUM = 8,
   parameter int AW       = 7,
   parameter int DW       = 8
);
   logic                   wr_req;
   logic [SRAM_NUM-1:0]    wr_mask;
   logic [SRAM_NUM*AW-1:0] wr_addr;
   logic [SRAM_NUM*DW-1:0] wr_data;
   logic                   wr_gnt;
   logic                   rd_req;
   logic [SRAM_NUM*AW-1:0] rd_addr;
   logic                   rd_gnt;
   logic                   rd_valid;
   logic [SRAM_NUM*DW-1:0] rd_data;
   logic                   sram_cen;
   logic [SRAM_NUM-1:0]    sram_wen;
   logic [SRAM_NUM*AW-1:0] sram_a;
   logic [SRAM_NUM*DW-1:0] sram_d;
   logic [SRAM_NUM*DW-1:0] sram_q;

   // Arbiter side
   modport slave (
      input  wr_req, wr_mask, wr_addr, wr_data, rd_req, rd_addr, sram_q,
      output wr_gnt, rd_gnt, rd_valid, rd_data, sram_cen, sram_wen, sram_a, sram_d
   );

   // Requester / array side
   modport master (
      output wr_req, wr_mask, wr_addr, wr_data, rd_req, rd_addr, sram_q,
      input  wr_gnt, rd_gnt, rd_valid, rd_data, sram_cen, sram_wen, sram_a, sram_d
   );
endinterface

// File: rtl/orsram_arb.sv
// Two-port arbiter and command sequencer for the output-row SRAM array.
// One operation per cycle is granted, registered into the command stage (C) that
// drives the macros, and reads return through stage R two cycles after the grant.
module orsram_arb #(
   parameter int SRAM_NUM = 8,
   parameter int AW       = 7,
   parameter int DW       = 8,
   parameter int WR_PRIO  = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   orsram_arb_if.slave  bus
);

   localparam int AWT = SRAM_NUM * AW;
   localparam int DWT = SRAM_NUM * DW;

   logic            last_wr_q, last_wr_d;
   logic            cen_q, cen_d;
   logic [SRAM_NUM-1:0] wen_q, wen_d;
   logic [AWT-1:0]  a_q, a_d;
   logic [DWT-1:0]  d_q, d_d;
   logic            rd_c_q, rd_c_d;
   logic            rd_v_q, rd_v_d;
   logic [DWT-1:0]  hold_q, hold_d;

   logic            wr_gnt;
   logic            rd_gnt;
   logic            contested;

   // Grant selection: lone requester wins; on contest either write priority or
   // alternate against the winner of the previous contest. No grants in reset.
   always_comb begin
      wr_gnt    = 1'b0;
      rd_gnt    = 1'b0;
      contested = bus.wr_req && bus.rd_req;
      if (rst_n) begin
         if (contested) begin
            if ((WR_PRIO != 0) || !last_wr_q) begin
               wr_gnt = 1'b1;
            end else begin
               rd_gnt = 1'b1;
            end
         end else begin
            wr_gnt = bus.wr_req;
            rd_gnt = bus.rd_req;
         end
      end
   end

   // Next state for the contest history, stage C and stage R.
   always_comb begin
      last_wr_d = last_wr_q;
      cen_d     = 1'b1;
      wen_d     = '1;
      a_d       = a_q;
      d_d       = d_q;
      rd_c_d    = 1'b0;
      rd_v_d    = rd_c_q;
      hold_d    = hold_q;

      if (contested) begin
         last_wr_d = wr_gnt;
      end

      if (wr_gnt) begin
         // Unmasked banks see CEN low with WEN high: a read whose Q is ignored.
         cen_d = 1'b0;
         wen_d = ~bus.wr_mask;
         a_d   = bus.wr_addr;
         d_d   = bus.wr_data;
      end else if (rd_gnt) begin
         cen_d  = 1'b0;
         a_d    = bus.rd_addr;
         rd_c_d = 1'b1;
      end

      // Keep the last returned word so rd_data is stable between pulses.
      if (rd_v_q) begin
         hold_d = bus.sram_q;
      end
   end

   // State registers with synchronous active-low reset; reset drops in-flight reads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_wr_q <= 1'b0;
         cen_q     <= 1'b1;
         wen_q     <= '1;
         a_q       <= '0;
         d_q       <= '0;
         rd_c_q    <= 1'b0;
         rd_v_q    <= 1'b0;
         hold_q    <= '0;
      end else begin
         last_wr_q <= last_wr_d;
         cen_q     <= cen_d;
         wen_q     <= wen_d;
         a_q       <= a_d;
         d_q       <= d_d;
         rd_c_q    <= rd_c_d;
         rd_v_q    <= rd_v_d;
         hold_q    <= hold_d;
      end
   end

   // The macro output register already holds the read word in the valid cycle,
   // so it is passed straight through then and the held copy is shown otherwise.
   assign bus.wr_gnt   = wr_gnt;
   assign bus.rd_gnt   = rd_gnt;
   assign bus.sram_cen = cen_q;
   assign bus.sram_wen = wen_q;
   assign bus.sram_a   = a_q;
   assign bus.sram_d   = d_q;
   assign bus.rd_valid = rd_v_q;
   assign bus.rd_data  = rd_v_q ? bus.sram_q : hold_q;

endmodule

// File: tb/tb_orsram_arb.sv
// Bench for orsram_arb: a behavioural SRAM array, a grant/memory reference model
// checked every cycle, vector tables for arbitration, directed corner sequences
// and a randomized phase with held requests.
module tb_orsram_arb;
   localparam int N  = 8;
   localparam int AW = 7;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic rst_n1;
   always #5 clk = ~clk;

   orsram_arb_if #(.SRAM_NUM(N), .AW(AW), .DW(DW)) b0 ();
   orsram_arb_if #(.SRAM_NUM(N), .AW(AW), .DW(DW)) b1 ();

   orsram_arb #(.SRAM_NUM(N), .AW(AW), .DW(DW), .WR_PRIO(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(b0));
   orsram_arb #(.SRAM_NUM(N), .AW(AW), .DW(DW), .WR_PRIO(1)) dut1 (
      .clk(clk), .rst_n(rst_n1), .bus(b1));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit mon_on = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural SRAM array for dut0 ----------------
   logic [7:0] sram_mem [N][128];
   always @(posedge clk) begin
      logic [N*DW-1:0] qn;
      qn = b0.sram_q;
      if (!b0.sram_cen) begin
         for (int i = 0; i < N; i++) begin
            qn[i*DW +: DW] = sram_mem[i][b0.sram_a[i*AW +: AW]];
            if (!b0.sram_wen[i]) sram_mem[i][b0.sram_a[i*AW +: AW]] = b0.sram_d[i*DW +: DW];
         end
      end
      b0.sram_q <= qn;
   end

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      int          due;
      logic [63:0] data;
   } exp_t;
   exp_t exp_q[$];

   logic [7:0]      ref_mem [N][128];
   bit              ref_last_wr;
   logic [63:0]     ref_hold;
   logic            e_cen;
   logic [N-1:0]    e_wen;
   logic [N*AW-1:0] e_a;
   logic [N*DW-1:0] e_d;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      bit ewg, erg, edue;
      logic [63:0] rdat;
      if (mon_on) begin
         chk("sram_cen", b0.sram_cen, e_cen);
         chk("sram_wen", b0.sram_wen, e_wen);
         chk("sram_a", b0.sram_a, e_a);
         chk("sram_d", b0.sram_d, e_d);
         edue = (exp_q.size() != 0) && (exp_q[0].due == cyc);
         chk("rd_valid", b0.rd_valid, edue);
         if (edue) begin
            if (b0.rd_valid) begin
               chk("rd_data", b0.rd_data, exp_q[0].data);
               ref_hold = exp_q[0].data;
            end
            void'(exp_q.pop_front());
         end else if (!b0.rd_valid) begin
            chk("rd_hold", b0.rd_data, ref_hold);
         end

         // Lone requester wins; a contest goes to whoever lost the previous contest.
         ewg = 1'b0;
         erg = 1'b0;
         if (rst_n) begin
            if (b0.wr_req && b0.rd_req) begin
               ewg = !ref_last_wr;
               erg = ref_last_wr;
            end else begin
               ewg = b0.wr_req;
               erg = b0.rd_req;
            end
         end
         chk("wr_gnt", b0.wr_gnt, ewg);
         chk("rd_gnt", b0.rd_gnt, erg);

         if (!rst_n) begin
            exp_q.delete();
            ref_last_wr = 1'b0;
            ref_hold = '0;
            e_cen = 1'b1;
            e_wen = '1;
            e_a = '0;
            e_d = '0;
         end else begin
            if (b0.wr_req && b0.rd_req) ref_last_wr = ewg;
            e_cen = 1'b1;
            e_wen = '1;
            if (ewg) begin
               e_cen = 1'b0;
               e_wen = ~b0.wr_mask;
               e_a = b0.wr_addr;
               e_d = b0.wr_data;
               for (int i = 0; i < N; i++)
                  if (b0.wr_mask[i]) ref_mem[i][b0.wr_addr[i*AW +: AW]] = b0.wr_data[i*DW +: DW];
            end else if (erg) begin
               e_cen = 1'b0;
               e_a = b0.rd_addr;
               for (int i = 0; i < N; i++) rdat[i*DW +: DW] = ref_mem[i][b0.rd_addr[i*AW +: AW]];
               exp_q.push_back('{due: cyc + 2, data: rdat});
            end
         end
      end
   end

   // ---------------- vector tables ----------------
   typedef struct {
      bit rst;
      bit wr;
      bit rd;
      bit ewg;
      bit erg;
   } vec_t;
   vec_t prio_tab[11];
   vec_t alt_tab[6];

   task automatic idle0();
      b0.wr_req = 1'b0;
      b0.rd_req = 1'b0;
   endtask

   task automatic set_wr(input logic [N-1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
      b0.wr_req  = 1'b1;
      b0.wr_mask = m;
      b0.wr_addr = {N{a}};
      b0.wr_data = {N{d}};
   endtask

   task automatic set_rd(input logic [AW-1:0] a);
      b0.rd_req  = 1'b1;
      b0.rd_addr = {N{a}};
   endtask

   initial begin
      bit wg, rg;
      prio_tab[0] = '{0, 1, 1, 0, 0};
      prio_tab[1] = '{1, 0, 0, 0, 0};
      prio_tab[2] = '{1, 1, 0, 1, 0};
      prio_tab[3] = '{1, 0, 1, 0, 1};
      for (int k = 4; k < 10; k++) prio_tab[k] = '{1, 1, 1, 1, 0};
      prio_tab[10] = '{1, 0, 0, 0, 0};
      for (int k = 0; k < 6; k++) alt_tab[k] = '{1, 1, 1, (k % 2 == 0), (k % 2 == 1)};

      for (int i = 0; i < N; i++)
         for (int j = 0; j < 128; j++) begin
            sram_mem[i][j] = '0;
            ref_mem[i][j]  = '0;
         end
      ref_last_wr = 1'b0;
      ref_hold = '0;
      e_cen = 1'b1;
      e_wen = '1;
      e_a = '0;
      e_d = '0;

      rst_n = 1'b0;
      rst_n1 = 1'b0;
      idle0();
      b0.wr_mask = '0; b0.wr_addr = '0; b0.wr_data = '0; b0.rd_addr = '0;
      b1.wr_req = 1'b0; b1.rd_req = 1'b0; b1.wr_mask = '1; b1.wr_addr = '0;
      b1.wr_data = '0; b1.rd_addr = '0; b1.sram_q = '0;

      // Reset, then idle
      tick(); tick();
      mon_on = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("idle_cen", b0.sram_cen, 1'b1);
         chk("idle_wen", b0.sram_wen, {N{1'b1}});
         chk("idle_rd_valid", b0.rd_valid, 1'b0);
         tick();
      end

      // Write-priority instance: table driven
      for (int k = 0; k < 11; k++) begin
         rst_n1 = prio_tab[k].rst;
         b1.wr_req = prio_tab[k].wr;
         b1.rd_req = prio_tab[k].rd;
         @(negedge clk);
         chk($sformatf("prio_wr_gnt[%0d]", k), b1.wr_gnt, prio_tab[k].ewg);
         chk($sformatf("prio_rd_gnt[%0d]", k), b1.rd_gnt, prio_tab[k].erg);
         tick();
      end
      b1.wr_req = 1'b0; b1.rd_req = 1'b0;

      // Round-robin alternation, first contest after reset goes to write
      for (int k = 0; k < 6; k++) begin
         b0.wr_req = alt_tab[k].wr;
         b0.rd_req = alt_tab[k].rd;
         b0.wr_mask = '1;
         b0.wr_addr = {N{7'h40}};
         b0.wr_data = {$urandom, $urandom};
         b0.rd_addr = {N{7'h41}};
         @(negedge clk);
         chk($sformatf("alt_wr_gnt[%0d]", k), b0.wr_gnt, alt_tab[k].ewg);
         chk($sformatf("alt_rd_gnt[%0d]", k), b0.rd_gnt, alt_tab[k].erg);
         tick();
      end
      idle0();
      tick(); tick(); tick();

      // Write 0xA5 at 0x12 then read it on the next cycle
      set_wr('1, 7'h12, 8'hA5);
      @(negedge clk);
      chk("t2_wr_gnt", b0.wr_gnt, 1'b1);
      tick();
      idle0();
      set_rd(7'h12);
      @(negedge clk);
      chk("t2_rd_gnt", b0.rd_gnt, 1'b1);
      tick();
      idle0();
      @(negedge clk);
      chk("t2_early_valid", b0.rd_valid, 1'b0);
      tick();
      @(negedge clk);
      chk("t2_rd_valid", b0.rd_valid, 1'b1);
      chk("t2_rd_data", b0.rd_data, {N{8'hA5}});
      tick();

      // Partial write over a 0xFF fill
      set_wr('1, 7'd5, 8'hFF);
      tick();
      set_wr(8'h01, 7'd5, 8'h3C);
      tick();
      idle0();
      set_rd(7'd5);
      tick();
      idle0();
      tick();
      @(negedge clk);
      chk("t3_rd_valid", b0.rd_valid, 1'b1);
      chk("t3_rd_data", b0.rd_data, {{7{8'hFF}}, 8'h3C});
      tick();

      // Preload 0..3 and read back-to-back
      for (int a = 0; a < 4; a++) begin
         set_wr('1, AW'(a), DW'(a));
         @(negedge clk);
         chk("t5_pre_gnt", b0.wr_gnt, 1'b1);
         tick();
      end
      idle0();
      for (int k = 0; k < 6; k++) begin
         if (k < 4) set_rd(AW'(k)); else idle0();
         @(negedge clk);
         if (k < 4) chk("t5_rd_gnt", b0.rd_gnt, 1'b1);
         if (k >= 2) begin
            chk("t5_valid", b0.rd_valid, 1'b1);
            chk("t5_data", b0.rd_data, {N{DW'(k - 2)}});
         end
         tick();
      end
      @(negedge clk);
      chk("t5_valid_end", b0.rd_valid, 1'b0);

      // Read granted, then reset at the next edge
      tick();
      set_rd(7'd3);
      @(negedge clk);
      chk("t6_rd_gnt", b0.rd_gnt, 1'b1);
      tick();
      idle0();
      rst_n = 1'b0;
      tick();
      set_wr('1, 7'd9, 8'h77);
      set_rd(7'd9);
      @(negedge clk);
      chk("t6_no_valid", b0.rd_valid, 1'b0);
      chk("t6_cen", b0.sram_cen, 1'b1);
      chk("t6_wen", b0.sram_wen, {N{1'b1}});
      chk("t6_a", b0.sram_a, '0);
      chk("t6_d", b0.sram_d, '0);
      chk("t6_rd_data", b0.rd_data, '0);
      chk("t6_gnt_in_reset", {b0.wr_gnt, b0.rd_gnt}, 2'b00);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_first_wr", b0.wr_gnt, 1'b1);
      chk("t6_first_rd", b0.rd_gnt, 1'b0);
      tick();
      b0.wr_req = 1'b0;
      @(negedge clk);
      chk("t6_then_rd", b0.rd_gnt, 1'b1);
      tick();
      idle0();
      tick(); tick(); tick();

      // Randomized traffic; requests hold their payload until granted
      wg = 1'b1;
      rg = 1'b1;
      for (int k = 0; k < 400; k++) begin
         if (!b0.wr_req || wg) begin
            b0.wr_req = ($urandom_range(0, 99) < 60);
            b0.wr_mask = N'($urandom);
            b0.wr_data = {$urandom, $urandom};
            for (int i = 0; i < N; i++) b0.wr_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
         end
         if (!b0.rd_req || rg) begin
            b0.rd_req = ($urandom_range(0, 99) < 60);
            for (int i = 0; i < N; i++) b0.rd_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
         end
         @(negedge clk);
         wg = b0.wr_gnt;
         rg = b0.rd_gnt;
         tick();
      end
      idle0();
      for (int k = 0; k < 4; k++) tick();
      chk("drain_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/orsram_arb.md
# orsram_arb

Two-port arbiter and sequencer for the output-row SRAM array: `SRAM_NUM` single-port 128x8 macros sharing one active-low chip enable, each with its own active-low write enable, 7-bit address, and 8-bit data. A write requester (layer result writeback) and a read requester (next-layer operand fetch) share the array. The block grants at most one operation per cycle, registers the macro command, and returns read data with fixed latency.

## Interface
- `SRAM_NUM`, 8, number of macros (banks).
- `AW`, 7, per-bank address width.
- `DW`, 8, per-bank data width.
- `WR_PRIO`, 0: 0 = round-robin between write and read; 1 = write always wins.

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `wr_req`  in  1  write request; held with its payload until granted.
- `wr_mask`  in  SRAM_NUM  banks to write (1 = write).
- `wr_addr`  in  SRAM_NUM*AW  per-bank address, bank i at [(i+1)*AW-1 -: AW].
- `wr_data`  in  SRAM_NUM*DW  per-bank write data.
- `wr_gnt`  out  1  write accepted this cycle (combinational).
- `rd_req`  in  1  read request; held with its payload until granted.
- `rd_addr`  in  SRAM_NUM*AW  per-bank read address.
- `rd_gnt`  out  1  read accepted this cycle (combinational).
- `rd_valid`  out  1  `rd_data` valid, one-cycle pulse.
- `rd_data`  out  SRAM_NUM*DW  registered read data, all banks.
- `sram_cen`  out  1  shared chip enable to the array, active low.
- `sram_wen`  out  SRAM_NUM  per-bank write enable, active low.
- `sram_a`  out  SRAM_NUM*AW  per-bank address.
- `sram_d`  out  SRAM_NUM*DW  per-bank write data.
- `sram_q`  in  SRAM_NUM*DW  macro outputs, valid the cycle after a CEN-low edge.

## Operation
- Arbitration happens each cycle over `wr_req` and `rd_req`. At most one of `wr_gnt` and `rd_gnt` is high, and a grant is only given with its request.
- Only one requester asserting: that requester is granted.
- Both asserting, `WR_PRIO`=0: the requester that did not win the last contested cycle is granted. The `last_wr` flop updates only on contested cycles. Its reset value is 0, so the first contest goes to write.
- Both asserting, `WR_PRIO`=1: write is granted.
- A granted command is registered into the command stage (stage C).
  - Write: `sram_cen`=0, `sram_wen[i]`=~`wr_mask[i]`, address and data taken from the write payload.
  - Read: `sram_cen`=0, `sram_wen` all 1, address from `rd_addr`, `sram_d` holds its previous value.
- No grant: stage C presents `sram_cen`=1 and `sram_wen` all 1. Address and data hold their previous values.
- A write with `wr_mask`=0 is still granted and consumes a slot. The array sees CEN low with all WEN high, which is a harmless read. No `rd_valid` results.
- Banks not in `wr_mask` perform a read during a partial write. Their Q is ignored.
- Read pipeline: a read flag travels with stage C into stage R. Stage R captures `sram_q` into `rd_data` and pulses `rd_valid`.
- Ordering is in program order because the array is single-ported. A read granted the cycle after a write to the same address returns the new data.

## Timing
- Grant cycle T (gnt high before edge T):
  - Array pins are driven in cycle T+1.
  - The macro samples at edge T+1.
  - `rd_data`/`rd_valid` are high in cycle T+2.
  - Read latency is 2 cycles from grant. Write completes at edge T+1.
- Throughput is one operation per cycle. Back-to-back reads give `rd_valid` on consecutive cycles.
- `rd_data` holds its value when `rd_valid`=0.
- Reset (`rst_n`=0 at an edge), including mid-operation:
  - `sram_cen`=1, `sram_wen` all 1.
  - `sram_a`=0, `sram_d`=0, `rd_data`=0, `rd_valid`=0, `last_wr`=0.
  - In-flight reads are dropped with no `rd_valid`.
  - Grants are forced low while `rst_n`=0.
  - A write granted in the cycle before reset is lost if its stage C is cleared.

## Test plan
- Reset, then idle 5 cycles → `sram_cen`=1, `sram_wen`=all 1, `rd_valid`=0 throughout.
- Write 0xA5 to all banks at address 0x12, then read 0x12 the next cycle → `wr_gnt` then `rd_gnt` on consecutive cycles. `rd_valid` is high 2 cycles after `rd_gnt`, with every byte of `rd_data`=0xA5.
- Write mask 0x01 with data 0x3C at address 5, over a prior fill of 0xFF → read of address 5 returns byte0=0x3C and bytes 1..7=0xFF.
- Both requests held for 6 cycles, `WR_PRIO`=0 → grants alternate W,R,W,R,W,R. With `WR_PRIO`=1 → 6 write grants and `rd_gnt`=0.
- Four back-to-back reads of addresses 0..3 (preloaded with value=addr) → `rd_valid` high 4 consecutive cycles with data 0,1,2,3 in order.
- Read granted, then `rst_n`=0 at the next edge → no `rd_valid` pulse, all outputs at their reset values; first grant after release goes to write when contested.
